// File: rtl/accumulator_var_seq.sv
// accumulator_var_seq
// Sums a programmable number of signed adder results into one wide
// two's-complement group sum. Each finished group produces a one-cycle o_valid
// pulse. o_data/o_ovf hold the last group result until the next one is produced.

module accumulator_var_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH:0]   i_data,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_clear,
  input  logic                  i_en,
  output logic                  o_valid,
  output logic [ACC_WIDTH-1:0]  o_data,
  output logic                  o_ovf,
  output logic                  o_busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};

  // Two's-complement overflow of a+b: operands share a sign that the sum lacks.
  function automatic logic add_ovf(input logic [ACC_WIDTH-1:0] a,
                                   input logic [ACC_WIDTH-1:0] b,
                                   input logic [ACC_WIDTH-1:0] s);
    add_ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) &&
              (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
  endfunction

  state_t                  r_state;
  logic [ACC_WIDTH-1:0]    r_acc;
  logic [LEN_WIDTH-1:0]    r_cnt;
  logic [LEN_WIDTH-1:0]    r_len_q;
  logic                    r_ovf;
  logic                    r_valid;
  logic [ACC_WIDTH-1:0]    r_data;
  logic                    r_res_ovf;

  logic [ACC_WIDTH-1:0]    w_term;
  logic [ACC_WIDTH-1:0]    w_sum;
  logic                    w_ovf_step;
  logic [LEN_WIDTH-1:0]    w_len_eff;
  logic [LEN_WIDTH-1:0]    w_cnt_nxt;
  logic                    w_last;

  // Sign-extend the incoming term to accumulator width.
  assign w_term = ACC_WIDTH'($signed(i_data));

  // Datapath: running sum, its overflow flag, effective length and group-end test.
  always_comb begin
    w_sum      = r_acc + w_term;
    w_ovf_step = add_ovf(r_acc, w_term, w_sum);
    w_cnt_nxt  = r_cnt + LEN_ONE;
    w_last     = (w_cnt_nxt == r_len_q);
    if (i_len == LEN_ZERO) begin
      w_len_eff = LEN_ONE;
    end else begin
      w_len_eff = i_len;
    end
  end

  // Group FSM: accumulates terms, handles abort and enable, registers results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= ACC_ZERO;
      r_cnt     <= LEN_ZERO;
      r_len_q   <= LEN_ZERO;
      r_ovf     <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= ACC_ZERO;
      r_res_ovf <= 1'b0;
    end else if (!i_en) begin
      // Disabled: everything frozen, only the result pulse is dropped.
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_clear) begin
        // Abort takes priority over a term; the last result stays visible.
        r_state <= IDLE;
        r_acc   <= ACC_ZERO;
        r_cnt   <= LEN_ZERO;
        r_ovf   <= 1'b0;
      end else if (i_valid) begin
        case (r_state)
          IDLE: begin
            r_len_q <= w_len_eff;
            r_acc   <= w_term;
            r_cnt   <= LEN_ONE;
            r_ovf   <= 1'b0;
            if (w_len_eff == LEN_ONE) begin
              // Single-term group completes immediately.
              r_data    <= w_term;
              r_res_ovf <= 1'b0;
              r_valid   <= 1'b1;
              r_state   <= IDLE;
            end else begin
              r_state <= ACC;
            end
          end
          ACC: begin
            if (w_last) begin
              r_data    <= w_sum;
              r_res_ovf <= r_ovf | w_ovf_step;
              r_valid   <= 1'b1;
              r_acc     <= ACC_ZERO;
              r_cnt     <= LEN_ZERO;
              r_ovf     <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_acc   <= w_sum;
              r_cnt   <= w_cnt_nxt;
              r_ovf   <= r_ovf | w_ovf_step;
              r_state <= ACC;
            end
          end
          default: begin
            // Unreachable encoding: recover to a clean idle state.
            r_state <= IDLE;
            r_acc   <= ACC_ZERO;
            r_cnt   <= LEN_ZERO;
            r_ovf   <= 1'b0;
          end
        endcase
      end else begin
        // No term this cycle: hold the partial group indefinitely.
        r_state <= r_state;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ovf   = r_res_ovf;
  assign o_busy  = (r_state == ACC);

endmodule
